// File: rtl/ext_irq_ctrl.sv
// External interrupt controller, requester side of the ExtIRQ/ExtIAck handshake.
// Device lines are synchronised and edge-detected. Each rising edge sets a sticky
// pending bit. The lowest-index unmasked pending source is presented to the core,
// and no new request is raised until the handler signals ERet.
//
// Handshake: ExtIRQ acts as "valid" and ExtIAck as "ready". The request is
// transferred at the rising clock edge where ExtIRQ=1 and ExtIAck=1. ExtIRQ and
// irq_id are stable from the edge that raises ExtIRQ until that transfer. The
// request is never withdrawn. ExtIAck is ignored whenever ExtIRQ=0. ERet is only
// meaningful after a transfer (SERV state) and is ignored elsewhere.
module ext_irq_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ExtIAck,
  input  logic             ERet,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [N_SRC-1:0] s1_q, s1_d;
  logic [N_SRC-1:0] s2_q, s2_d;
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] overrun_q, overrun_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             ack_accept;

  // Two-flop synchroniser per line, plus a delayed copy for rising-edge detection.
  always_comb begin
    s1_d   = irq_in;
    s2_d   = s1_q;
    prev_d = s2_q;
    rise   = s2_q & ~prev_q;
  end

  // Pick the lowest-index pending source that is not masked.
  always_comb begin
    eligible = pending_q & ~irq_mask;
    winner   = '0;
    found    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i] && !found) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Update pending and overrun bits.
  // A new edge arriving at the ack edge keeps the bit pending, and overrun is left untouched.
  always_comb begin
    ack_accept = (state_q == ST_REQ) && ExtIAck;
    clr        = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = ack_accept && (irq_id_q == ID_W'(i));
    end
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = (overrun_q & ~(clr & ~rise)) | (rise & pending_q & ~clr);
  end

  // Request FSM: IDLE selects a winner, REQ waits for ack, SERV waits for end of handler.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible != '0) begin
          irq_id_d = winner;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ExtIAck) begin
          state_d = ST_SERV;
        end
      end
      ST_SERV: begin
        if (ERet) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state registers. Reset discards any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      irq_id_q  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // ExtIRQ is decoded straight from the state register, so it is glitch-free.
  assign ExtIRQ    = (state_q == ST_REQ);
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule
